csa_adder3: RTL and testbench

- Registered three-operand unsigned adder built on carry-save (3:2 compressor) architecture.
- Reduces op_A, op_B and op_C to a sum vector and a carry vector with one row of full adders, then resolves them with a final carry-propagate adder.
- Used wherever three DATA_W operands must be summed without chaining two ripple adders, e.g. accumulators and multiplier partial-product trees.

---
 rtl/csa_adder3_pkg.sv | 22 ++
 rtl/csa_full_adder.sv | 20 ++
 rtl/csa_adder3.sv | 96 +++++++++
 tb/tb_csa_adder3.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/csa_adder3_pkg.sv
// +---------------------------------------------------------------------------+
// | csa_adder3_pkg: shared width helper and pipeline latency for csa_adder3.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package csa_adder3_pkg;

  // Three DATA_W operands sum to at most 3*(2^DATA_W-1), which needs two extra bits.
  function automatic int res_width(input int data_w);
    return data_w + 2;
  endfunction

`ifdef CSA_ADDER3_PIPE_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif

endpackage : csa_adder3_pkg

`default_nettype wire

// File: rtl/csa_full_adder.sv
// +---------------------------------------------------------------------------+
// | csa_full_adder: single-bit 3:2 compressor cell used by the CSA row.        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module csa_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : csa_full_adder

`default_nettype wire

// File: rtl/csa_adder3.sv
// +---------------------------------------------------------------------------+
// | csa_adder3: registered three-operand unsigned adder, one CSA row followed  |
// | by a carry-propagate add. Macro CSA_ADDER3_PIPE_EN adds a CSA->CPA stage.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module csa_adder3
  import csa_adder3_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             op_A,
  input  logic [DATA_W-1:0]             op_B,
  input  logic [DATA_W-1:0]             op_C,
  output logic                          out_valid,
  output logic [res_width(DATA_W)-1:0]  res
);

  localparam int RES_W = res_width(DATA_W);

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W:0]   w_carry;
  logic [DATA_W-1:0] w_cpa_sum;
  logic [DATA_W:0]   w_cpa_carry;
  logic              w_cpa_valid;
  logic [RES_W-1:0]  w_res;
  logic [RES_W-1:0]  r_res;
  logic              r_valid;

  assign w_carry[0] = 1'b0;

  generate
    for (genvar i = 0; i < DATA_W; i++) begin : g_fa
      csa_full_adder u_fa (
        .a    (op_A[i]),
        .b    (op_B[i]),
        .cin  (op_C[i]),
        .sum  (w_sum[i]),
        .cout (w_carry[i+1])
      );
    end
  endgenerate

`ifdef CSA_ADDER3_PIPE_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W:0]   r_carry;
  logic              r_pipe_valid;

  // Vectors only load on valid so idle (possibly undefined) operands never reach res.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum        <= '0;
      r_carry      <= '0;
      r_pipe_valid <= 1'b0;
    end else begin
      r_pipe_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
      end
    end
  end

  assign w_cpa_sum   = r_sum;
  assign w_cpa_carry = r_carry;
  assign w_cpa_valid = r_pipe_valid;
`else
  assign w_cpa_sum   = w_sum;
  assign w_cpa_carry = w_carry;
  assign w_cpa_valid = in_valid;
`endif

  assign w_res = {2'b00, w_cpa_sum} + {1'b0, w_cpa_carry};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_cpa_valid;
      if (w_cpa_valid) begin
        r_res <= w_res;
      end
    end
  end

  assign res       = r_res;
  assign out_valid = r_valid;

endmodule : csa_adder3

`default_nettype wire

// File: tb/tb_csa_adder3.sv
// +---------------------------------------------------------------------------+
// | tb_csa_adder3: scoreboard bench for csa_adder3 (result value and latency). |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_csa_adder3;
  import csa_adder3_pkg::*;

  parameter int DATA_W = 8;
  localparam int RES_W = DATA_W + 2;

  typedef struct {
    logic [RES_W-1:0] val;
    int               cyc;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] op_A;
  logic [DATA_W-1:0] op_B;
  logic [DATA_W-1:0] op_C;
  logic              out_valid;
  logic [RES_W-1:0]  res;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [RES_W-1:0] last_exp;

  csa_adder3 #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .op_A      (op_A),
    .op_B      (op_B),
    .op_C      (op_C),
    .out_valid (out_valid),
    .res       (res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [DATA_W-1:0] c);
    exp_t e;
    @(negedge clk);
    op_A     = a;
    op_B     = b;
    op_C     = c;
    in_valid = 1'b1;
    e.val    = RES_W'(a) + RES_W'(b) + RES_W'(c);
    e.cyc    = cyc;
    last_exp = e.val;
    exp_q.push_back(e);
  endtask

  task automatic idle_rand();
    @(negedge clk);
    in_valid = 1'b0;
    op_A     = DATA_W'($urandom());
    op_B     = DATA_W'($urandom());
    op_C     = DATA_W'($urandom());
  endtask

  // Output monitor: every valid result must match the oldest expectation, LATENCY cycles on.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(out_valid), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("res", 64'(res), 64'(mon_e.val));
        check("latency", 64'(cyc - mon_e.cyc), 64'(LATENCY));
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] msb;
    logic [DATA_W-1:0] alt;

    ones = '1;
    msb  = '0;
    msb[DATA_W-1] = 1'b1;
    for (int i = 0; i < DATA_W; i++) alt[i] = (i % 2 == 1);

    rst = 1'b1; in_valid = 1'b0; op_A = '0; op_B = '0; op_C = '0;
    repeat (2) @(negedge clk);
    check("reset_res", 64'(res), 64'(0));
    check("reset_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;

    // Directed patterns, back-to-back
    send(ones, ones, ones);
    send('0, '0, '0);
    send(DATA_W'(1), '0, '0);
    send(msb, msb, msb);
    send(alt, ~alt, DATA_W'(1));
    repeat (LATENCY + 2) idle_rand();
    check("drain_directed", 64'(exp_q.size()), 64'(0));

    // Idle with changing operands: res holds, out_valid low
    for (int k = 0; k < 4; k++) begin
      idle_rand();
      @(posedge clk); #1;
      check("hold_res", 64'(res), 64'(last_exp));
      check("hold_valid", 64'(out_valid), 64'(0));
    end

    // Asynchronous reset between edges while streaming
    for (int k = 0; k < 5; k++)
      send(DATA_W'($urandom()), DATA_W'($urandom()), DATA_W'($urandom()));
    @(posedge clk); #3;
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_res", 64'(res), 64'(0));
    check("async_rst_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_rst_valid", 64'(out_valid), 64'(0));
      check("post_rst_res", 64'(res), 64'(0));
    end

    // Random back-to-back stream
    for (int k = 0; k < 1000; k++)
      send(DATA_W'($urandom()), DATA_W'($urandom()), DATA_W'($urandom()));
    send(ones, ones, ones);
    repeat (LATENCY + 2) idle_rand();
    check("drain_random", 64'(exp_q.size()), 64'(0));
    check("final_hold", 64'(res), 64'(3 * ((64'(1) << DATA_W) - 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_csa_adder3

`default_nettype wire
